dac_serial_rx: RTL and testbench

//  Receiving end of the chip-select-framed serial link driven by the ROM-word serializer.
//  - Samples the MSB-first bit stream on sdi while cs_i frames it.
//  - Reassembles 8-bit words and presents them through a one-entry valid/ready buffer.
//  - Flags incomplete frames and buffer overruns.
//  - Sits at the DAC/loopback side, clocked by the same clk_cs as the serializer.

---
 rtl/dac_serial_rx_pkg.sv | 15 +
 rtl/dac_serial_rx_word_buf.sv | 51 +++++
 rtl/dac_serial_rx.sv | 104 ++++++++++
 tb/tb_dac_serial_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_serial_rx_pkg.sv
// Shared definitions for the serial receive path.
//  CS_O_ENABLE : level of cs_i that frames a transfer (shared with the serializer)
//  RX_DW       : default word width
//  rx_state_t  : receiver FSM encoding (RX_IDLE / RX_SHIFT)
package dac_serial_rx_pkg;

    localparam logic CS_O_ENABLE = 1'b0;
    localparam int   RX_DW       = 8;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/dac_serial_rx_word_buf.sv
// One-entry valid/ready holding buffer for reassembled words.
//  clk_cs, rst  : link clock, async active-high reset
//  word_done    : a complete word is presented on word this cycle
//  word         : completed word
//  rdy_i        : downstream ready
//  data_o       : held word
//  valid_o      : data_o holds an unconsumed word
//  word_cnt_o   : words accepted into the buffer, wraps
//  ovf_o        : 1-cycle pulse, word dropped because buffer full and !rdy_i
module dac_serial_rx_word_buf #(
    parameter int DW  = 8,
    parameter int WCW = 8
) (
    input  logic           clk_cs,
    input  logic           rst,
    input  logic           word_done,
    input  logic [DW-1:0]  word,
    input  logic           rdy_i,
    output logic [DW-1:0]  data_o,
    output logic           valid_o,
    output logic [WCW-1:0] word_cnt_o,
    output logic           ovf_o
);

    logic take;
    logic accept;

    // A word can load into an empty buffer, or into a full one that is
    // draining on this very edge (so valid_o stays high without a bubble).
    assign take   = valid_o && rdy_i;
    assign accept = word_done && (!valid_o || rdy_i);

    always_ff @(posedge clk_cs or posedge rst) begin
        if (rst) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            word_cnt_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            ovf_o <= word_done && valid_o && !rdy_i;
            if (accept) begin
                data_o     <= word;
                valid_o    <= 1'b1;
                word_cnt_o <= word_cnt_o + 1'b1;
            end else if (take) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dac_serial_rx.sv
// Receiver for the chip-select-framed, MSB-first serial link.
// Samples sdi while cs_i frames it, reassembles DW-bit words and hands them
// to a one-entry valid/ready buffer. Flags partial frames and overruns.
//  clk_cs, rst  : link clock, async active-high reset
//  cs_i         : frame select, active at CS_O_ENABLE
//  sdi          : serial data, MSB first
//  rdy_i        : downstream ready
//  data_o       : last completed word
//  valid_o      : data_o unconsumed
//  bit_idx_o    : bits of current word received so far
//  word_cnt_o   : accepted word count, wraps
//  frame_err_o  : 1-cycle pulse, frame ended mid-word
//  ovf_o        : 1-cycle pulse, word dropped on full buffer
// BCW must satisfy 2**BCW > DW.
module dac_serial_rx
    import dac_serial_rx_pkg::*;
#(
    parameter int DW  = RX_DW,
    parameter int BCW = 4,
    parameter int WCW = 8
) (
    input  logic           clk_cs,
    input  logic           rst,
    input  logic           cs_i,
    input  logic           sdi,
    input  logic           rdy_i,
    output logic [DW-1:0]  data_o,
    output logic           valid_o,
    output logic [BCW-1:0] bit_idx_o,
    output logic [WCW-1:0] word_cnt_o,
    output logic           frame_err_o,
    output logic           ovf_o
);

    rx_state_t      state;
    // Only the DW-1 leading bits of a word need storing; the last bit is
    // taken straight from sdi on the completing edge.
    logic [DW-2:0]  shreg;
    logic [BCW-1:0] bit_idx;

    logic           cs_act;
    logic           last_bit;
    logic [BCW-1:0] idx_next;
    logic [DW-1:0]  word;

    assign cs_act   = (cs_i == CS_O_ENABLE);
    assign last_bit = (state == RX_SHIFT) && (bit_idx == BCW'(DW-1));
    assign idx_next = last_bit ? '0 : bit_idx + 1'b1;
    assign word     = {shreg, sdi};

    // IDLE only arms on cs: the transmitter drives its first bit on that same
    // edge, so the first valid sample is one edge later in SHIFT. SHIFT keeps
    // sampling on the edge where cs drops, since that bit was launched while
    // cs was still active.
    always_ff @(posedge clk_cs or posedge rst) begin
        if (rst) begin
            state       <= RX_IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (cs_act) begin
                        state   <= RX_SHIFT;
                        bit_idx <= '0;
                    end
                end
                RX_SHIFT: begin
                    shreg <= word[DW-2:0];
                    if (cs_act) begin
                        bit_idx <= idx_next;
                    end else begin
                        // Leftover bits of a partial word are simply dropped;
                        // the next word rebuilds shreg from scratch.
                        state       <= RX_IDLE;
                        bit_idx     <= '0;
                        frame_err_o <= (idx_next != '0);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign bit_idx_o = bit_idx;

    dac_serial_rx_word_buf #(
        .DW  (DW),
        .WCW (WCW)
    ) u_buf (
        .clk_cs     (clk_cs),
        .rst        (rst),
        .word_done  (last_bit),
        .word       (word),
        .rdy_i      (rdy_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .word_cnt_o (word_cnt_o),
        .ovf_o      (ovf_o)
    );

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx. Drives a model of the serializer
// (bit j of a frame launched just after edge n+j) and logs the DUT outputs
// after each edge n+k so checks can refer to edge offsets.
module tb_dac_serial_rx;
    import dac_serial_rx_pkg::*;

    logic       clk_cs = 1'b0;
    logic       rst    = 1'b1;
    logic       cs_i   = ~CS_O_ENABLE;
    logic       sdi    = 1'b0;
    logic       rdy_i  = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] bit_idx_o;
    logic [7:0] word_cnt_o;
    logic       frame_err_o;
    logic       ovf_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] lg_data  [0:32];
    logic       lg_valid [0:32];
    logic [3:0] lg_idx   [0:32];
    logic [7:0] lg_cnt   [0:32];
    logic       lg_err   [0:32];
    logic       lg_ovf   [0:32];
    logic       any_err;
    logic       any_ovf;

    dac_serial_rx dut (
        .clk_cs      (clk_cs),
        .rst         (rst),
        .cs_i        (cs_i),
        .sdi         (sdi),
        .rdy_i       (rdy_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .bit_idx_o   (bit_idx_o),
        .word_cnt_o  (word_cnt_o),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_cs = ~clk_cs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic log_at(input int k);
        lg_data[k]  = data_o;
        lg_valid[k] = valid_o;
        lg_idx[k]   = bit_idx_o;
        lg_cnt[k]   = word_cnt_o;
        lg_err[k]   = frame_err_o;
        lg_ovf[k]   = ovf_o;
        any_err     = any_err | frame_err_o;
        any_ovf     = any_ovf | ovf_o;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        cs_i  = ~CS_O_ENABLE;
        sdi   = 1'b0;
        rdy_i = 1'b0;
        @(posedge clk_cs);
        #1 rst = 1'b0;
    endtask

    // stream is left-aligned: bit j of the frame is stream[31-j].
    // rdy_i is rdy_val throughout, except high for edge n+rdy_at when rdy_at>0.
    task automatic frame(input logic [31:0] stream, input int len,
                         input logic rdy_val, input int rdy_at);
        any_err = 1'b0;
        any_ovf = 1'b0;
        rdy_i   = rdy_val;
        cs_i    = CS_O_ENABLE;
        @(posedge clk_cs);                       // edge n
        for (int j = 0; j < len; j++) begin
            #1;
            log_at(j);
            sdi   = stream[31-j];
            rdy_i = (rdy_at == j + 1) ? 1'b1 : rdy_val;
            if (j == len - 1) cs_i = ~CS_O_ENABLE;
            @(posedge clk_cs);                   // edge n+j+1
        end
        #1;
        log_at(len);
        sdi   = 1'b0;
        rdy_i = rdy_val;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_data",  data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_idx",   bit_idx_o, 0);
        chk("rst_cnt",   word_cnt_o, 0);
        chk("rst_err",   frame_err_o, 0);
        chk("rst_ovf",   ovf_o, 0);

        // single word
        frame({8'hA5, 24'h0}, 8, 1'b1, 0);
        chk("a5_idx3",   lg_idx[3], 3);
        chk("a5_val7",   lg_valid[7], 0);
        chk("a5_data7",  lg_data[7], 8'h00);
        chk("a5_val8",   lg_valid[8], 1);
        chk("a5_data8",  lg_data[8], 8'hA5);
        chk("a5_cnt8",   lg_cnt[8], 1);
        chk("a5_idx8",   lg_idx[8], 0);
        chk("a5_err",    any_err, 0);
        chk("a5_ovf",    any_ovf, 0);
        @(posedge clk_cs); #1;
        chk("a5_drain",  valid_o, 0);

        // back-to-back words in one frame
        do_reset();
        frame({8'h3C, 8'hC3, 16'h0}, 16, 1'b1, 0);
        chk("bb_data8",  lg_data[8], 8'h3C);
        chk("bb_val8",   lg_valid[8], 1);
        chk("bb_val9",   lg_valid[9], 0);
        chk("bb_idx12",  lg_idx[12], 4);
        chk("bb_val15",  lg_valid[15], 0);
        chk("bb_data16", lg_data[16], 8'hC3);
        chk("bb_val16",  lg_valid[16], 1);
        chk("bb_cnt16",  lg_cnt[16], 2);
        chk("bb_err",    any_err, 0);
        chk("bb_ovf",    any_ovf, 0);

        // backpressure / overrun
        do_reset();
        frame({8'h11, 8'h22, 16'h0}, 16, 1'b0, 0);
        chk("bp_data8",  lg_data[8], 8'h11);
        chk("bp_cnt8",   lg_cnt[8], 1);
        chk("bp_ovf15",  lg_ovf[15], 0);
        chk("bp_ovf16",  lg_ovf[16], 1);
        chk("bp_data16", lg_data[16], 8'h11);
        chk("bp_val16",  lg_valid[16], 1);
        chk("bp_cnt16",  lg_cnt[16], 1);
        rdy_i = 1'b1;
        @(posedge clk_cs); #1;
        chk("bp_drain",  valid_o, 0);
        chk("bp_ovf_end", ovf_o, 0);

        // short frame, then a clean frame restarting right after it
        do_reset();
        frame({5'b10110, 27'h0}, 5, 1'b1, 0);
        chk("sf_idx4",   lg_idx[4], 4);
        chk("sf_err4",   lg_err[4], 0);
        chk("sf_err5",   lg_err[5], 1);
        chk("sf_val5",   lg_valid[5], 0);
        chk("sf_idx5",   lg_idx[5], 0);
        chk("sf_cnt5",   lg_cnt[5], 0);
        frame({8'h5A, 24'h0}, 8, 1'b1, 0);
        chk("sf_err_clr", lg_err[0], 0);
        chk("sf2_data8", lg_data[8], 8'h5A);
        chk("sf2_val8",  lg_valid[8], 1);
        chk("sf2_cnt8",  lg_cnt[8], 1);
        chk("sf2_err",   any_err, 0);

        // one-cycle cs pulse
        frame({1'b1, 31'h0}, 1, 1'b1, 0);
        chk("p1_err",    lg_err[1], 1);

        // reset mid-frame, with a word also sitting in the buffer
        do_reset();
        frame({8'h66, 24'h0}, 8, 1'b0, 0);
        chk("rm_pre_val", lg_valid[8], 1);
        cs_i = CS_O_ENABLE;
        @(posedge clk_cs);
        for (int j = 0; j < 4; j++) begin
            #1 sdi = j[0];
            @(posedge clk_cs);
        end
        #1;
        chk("rm_idx4",   bit_idx_o, 4);
        rst = 1'b1;
        #1;
        chk("rm_data",   data_o, 0);
        chk("rm_valid",  valid_o, 0);
        chk("rm_idx",    bit_idx_o, 0);
        chk("rm_cnt",    word_cnt_o, 0);
        chk("rm_err",    frame_err_o, 0);
        chk("rm_ovf",    ovf_o, 0);
        cs_i = ~CS_O_ENABLE;
        sdi  = 1'b0;
        @(posedge clk_cs);
        #1 rst = 1'b0;
        frame({8'hFF, 24'h0}, 8, 1'b1, 0);
        chk("rm_ff_data", lg_data[8], 8'hFF);
        chk("rm_ff_val",  lg_valid[8], 1);
        chk("rm_ff_cnt",  lg_cnt[8], 1);
        chk("rm_ff_err",  any_err, 0);

        // load on the same edge the held word drains
        do_reset();
        frame({8'h66, 24'h0}, 8, 1'b0, 0);
        frame({8'h77, 24'h0}, 8, 1'b0, 8);
        chk("sim_data7", lg_data[7], 8'h66);
        chk("sim_val7",  lg_valid[7], 1);
        chk("sim_data8", lg_data[8], 8'h77);
        chk("sim_val8",  lg_valid[8], 1);
        chk("sim_cnt8",  lg_cnt[8], 2);
        chk("sim_ovf",   any_ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
